// File: rtl/pc_pkg.sv
// Shared types and constants for the multi-cycle MIPS program-counter block.
package pc_pkg;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0040_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0040_0180;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_LOAD   = 3'd4
  } next_sel_t;

  typedef enum logic {
    NORMAL = 1'b0,
    EXC    = 1'b1
  } pc_state_t;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular history of committed PCs; index 0 reads the newest entry.
module pc_trace_buf #(
  parameter int XLEN        = 32,
  parameter int TRACE_DEPTH = 8,
  parameter int IW          = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_data,
  input  logic [IW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [TRACE_DEPTH-1:0][XLEN-1:0] entries;
  logic [IW-1:0]                    wptr;
  logic [IW-1:0]                    rptr;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      entries <= '0;
      wptr    <= '0;
    end else if (wr_en) begin
      entries[wptr] <= wr_data;
      wptr          <= wptr + IW'(1);
    end
  end

  // wptr points at the slot to be overwritten next, so newest is wptr-1
  assign rptr    = wptr - IW'(1) - rd_idx;
  assign rd_data = entries[rptr];

endmodule

// File: rtl/pc_unit.sv
// Program counter with internal next-PC selection and EPC-based exception entry/return.
// Optional PC history buffer enabled by defining PC_TRACE_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(PC_EXC_VECTOR),
  parameter int              TRACE_DEPTH  = 8,
  parameter int              TIW          = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic [2:0]      next_sel,
  input  logic [15:0]     branch_imm,
  input  logic [25:0]     jump_idx,
  input  logic [XLEN-1:0] jr_addr,
  input  logic [XLEN-1:0] data_in,
  input  logic            exc_req,
  input  logic            eret,
  input  logic            read,
  output logic [XLEN-1:0] pc_const,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc_out,
  output logic            in_exc,
  output logic            misaligned
`ifdef PC_TRACE_EN
  ,
  input  logic [TIW-1:0]  trace_idx,
  output logic [XLEN-1:0] trace_pc
`endif
);

  pc_state_t       state;
  logic [XLEN-1:0] pc, epc;
  logic [XLEN-1:0] raw_target;
  logic            sel_valid;
  logic            take_exc, take_eret, take_write;

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    raw_target = pc;
    sel_valid  = 1'b1;
    case (next_sel)
      SEL_SEQ:    raw_target = pc_plus4;
      SEL_BRANCH: raw_target = pc_plus4 + {{(XLEN-18){branch_imm[15]}}, branch_imm, 2'b00};
      SEL_JUMP:   raw_target = {pc_plus4[XLEN-1:28], jump_idx, 2'b00};
      SEL_JR:     raw_target = jr_addr;
      SEL_LOAD:   raw_target = data_in;
      default:    sel_valid  = 1'b0;
    endcase
  end

  // Flag only; trapping on it is the control FSM's decision
  assign misaligned = sel_valid && (raw_target[1:0] != 2'b00);

  // exc_req in EXC is dropped, letting eret/pc_write through
  assign take_exc   = exc_req && (state == NORMAL);
  assign take_eret  = !take_exc && eret && (state == EXC);
  assign take_write = !take_exc && !take_eret && pc_write && sel_valid;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_VECTOR;
      epc   <= '0;
      state <= NORMAL;
    end else if (take_exc) begin
      epc   <= pc;
      pc    <= EXC_VECTOR;
      state <= EXC;
    end else if (take_eret) begin
      pc    <= epc;
      state <= NORMAL;
    end else if (take_write) begin
      pc    <= {raw_target[XLEN-1:2], 2'b00};
    end
  end

  assign pc_const = pc;
  assign data_out = read ? pc : '0;
  assign epc_out  = epc;
  assign in_exc   = (state == EXC);

`ifdef PC_TRACE_EN
  logic [XLEN-1:0] trace_wdata;

  always_comb begin
    trace_wdata = {raw_target[XLEN-1:2], 2'b00};
    if (take_exc)       trace_wdata = EXC_VECTOR;
    else if (take_eret) trace_wdata = epc;
  end

  pc_trace_buf #(
    .XLEN        (XLEN),
    .TRACE_DEPTH (TRACE_DEPTH),
    .IW          (TIW)
  ) u_trace (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (take_exc || take_eret || take_write),
    .wr_data (trace_wdata),
    .rd_idx  (trace_idx),
    .rd_data (trace_pc)
  );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; state changes on clk negedge, checks on posedge+1.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [2:0]  next_sel;
  logic [15:0] branch_imm;
  logic [25:0] jump_idx;
  logic [31:0] jr_addr, data_in;
  logic        exc_req, eret, read;
  logic [31:0] pc_const, data_out, pc_plus4, epc_out;
  logic        in_exc, misaligned;
`ifdef PC_TRACE_EN
  logic [2:0]  trace_idx;
  logic [31:0] trace_pc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_write   (pc_write),
    .next_sel   (next_sel),
    .branch_imm (branch_imm),
    .jump_idx   (jump_idx),
    .jr_addr    (jr_addr),
    .data_in    (data_in),
    .exc_req    (exc_req),
    .eret       (eret),
    .read       (read),
    .pc_const   (pc_const),
    .data_out   (data_out),
    .pc_plus4   (pc_plus4),
    .epc_out    (epc_out),
    .in_exc     (in_exc),
    .misaligned (misaligned)
`ifdef PC_TRACE_EN
    ,
    .trace_idx  (trace_idx),
    .trace_pc   (trace_pc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One falling (active) edge, then settle just after the following rising edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_write = 1'b0; exc_req = 1'b0; eret = 1'b0; next_sel = 3'd0;
  endtask

  initial begin
    rst = 1'b0; read = 1'b0; branch_imm = '0; jump_idx = '0;
    jr_addr = '0; data_in = '0;
    idle();
`ifdef PC_TRACE_EN
    trace_idx = '0;
`endif

    // Asynchronous reset, no edge needed
    #2 rst = 1'b1; read = 1'b1;
    #1;
    chk("rst_pc", pc_const, 32'h0040_0000);
    chk("rst_data_out", data_out, 32'h0040_0000);
    chk("rst_in_exc", {31'b0, in_exc}, 32'd0);
    chk("rst_epc", epc_out, 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    read = 1'b0; #1;
    chk("data_out_no_read", data_out, 32'd0);

    pc_write = 1'b1; next_sel = 3'd0; tick();
    chk("seq", pc_const, 32'h0040_0004);
    next_sel = 3'd1; branch_imm = 16'hFFFF; tick();
    chk("branch_neg", pc_const, 32'h0040_0004);
    next_sel = 3'd2; jump_idx = 26'h0100010; tick();
    chk("jump", pc_const, 32'h0040_0040);

    // pc_write=0 holds, while misaligned still reflects the raw target
    idle(); next_sel = 3'd3; jr_addr = 32'h0040_0013; #1;
    chk("misaligned_no_write", {31'b0, misaligned}, 32'd1);
    tick();
    chk("hold_no_write", pc_const, 32'h0040_0040);
    pc_write = 1'b1; tick();
    chk("jr_aligned", pc_const, 32'h0040_0010);

    next_sel = 3'd4; data_in = 32'h0040_0020; tick();
    chk("load", pc_const, 32'h0040_0020);
    chk("misaligned_clear", {31'b0, misaligned}, 32'd0);

    // Exception entry overrides pc_write
    next_sel = 3'd0; exc_req = 1'b1; tick();
    chk("exc_pc", pc_const, 32'h0040_0180);
    chk("exc_epc", epc_out, 32'h0040_0020);
    chk("exc_in_exc", {31'b0, in_exc}, 32'd1);
    pc_write = 1'b0; tick();
    chk("nested_epc", epc_out, 32'h0040_0020);
    chk("nested_pc", pc_const, 32'h0040_0180);
    // exc_req+eret in EXC: eret wins
    eret = 1'b1; tick();
    chk("eret_pc", pc_const, 32'h0040_0020);
    chk("eret_in_exc", {31'b0, in_exc}, 32'd0);
    idle();

    pc_write = 1'b1; next_sel = 3'd4; data_in = 32'hFFFF_FFFC; tick();
    chk("load_top", pc_const, 32'hFFFF_FFFC);
    next_sel = 3'd0; tick();
    chk("seq_wrap", pc_const, 32'h0000_0000);

    next_sel = 3'd6; #1;
    chk("reserved_misaligned", {31'b0, misaligned}, 32'd0);
    tick();
    chk("reserved_hold", pc_const, 32'h0000_0000);

    next_sel = 3'd0; eret = 1'b1; tick();
    chk("stray_eret_pc", pc_const, 32'h0000_0004);
    chk("stray_eret_in_exc", {31'b0, in_exc}, 32'd0);
    idle();

    // Reset mid-cycle with nonzero EPC must clear everything
    #2 rst = 1'b1; #1;
    chk("midrst_pc", pc_const, 32'h0040_0000);
    chk("midrst_epc", epc_out, 32'd0);
    #1 rst = 1'b0;

`ifdef PC_TRACE_EN
    @(posedge clk); #1;
    pc_write = 1'b1; next_sel = 3'd0;
    for (int i = 0; i < 10; i++) tick();
    idle();
    chk("trace_pc_after10", pc_const, 32'h0040_0028);
    trace_idx = 3'd0; #1;
    chk("trace_newest", trace_pc, 32'h0040_0028);
    trace_idx = 3'd7; #1;
    chk("trace_oldest", trace_pc, 32'h0040_000C);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
